// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake and operand/result bus for serial_adder.
// The master drives the request and operands; the slave returns the result.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             busy;
   logic             done;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
      input  ovf,
`endif
      input  sum, carry, busy, done
   );

   modport slave (
      input  start, a, b, cin,
`ifdef SERIAL_ADDER_OVF_EN
      output ovf,
`endif
      output sum, carry, busy, done
   );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder evaluation per clock, LSB first.
// A carry flop feeds the carry of each bit back into the next one; the result
// is published to sum/carry only when the last bit has been computed.
// Optional macro SERIAL_ADDER_OVF_EN adds the two's-complement overflow flag.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   serial_adder_if.slave bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] acc_q;
   logic             cy_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;

   logic             s_d;
   logic             cy_d;
   logic [WIDTH-1:0] acc_d;

   // The single reused full-adder cell: returns {carry_out, sum_bit}.
   function automatic logic [1:0] full_adder(input logic x, input logic y, input logic c);
      full_adder = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
   endfunction

   // Current-bit sum/carry and the accumulator with the new bit entering at the MSB.
   always_comb begin
      {cy_d, s_d} = full_adder(a_sh_q[0], b_sh_q[0], cy_q);
      acc_d       = (acc_q >> 1) | (WIDTH'(s_d) << (WIDTH - 1));
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // Overflow compares the carry into the MSB stage (cy_q on the last bit) with its carry-out.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == RUN && cnt_q == LAST_BIT) begin
         ovf_q <= cy_q ^ cy_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

   // Control FSM with registered outputs; datapath registers advance only in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sh_q  <= bus.a;
                  b_sh_q  <= bus.b;
                  cy_q    <= bus.cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               acc_q  <= acc_d;
               cy_q   <= cy_d;
               if (cnt_q == LAST_BIT) begin
                  // Last bit: publish the complete result in one step.
                  sum_q   <= acc_d;
                  carry_q <= cy_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sum   = sum_q;
   assign bus.carry = carry_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table, reset abort, held-start, random and exhaustive
// checks of serial_adder (WIDTH=4) against a plain-arithmetic reference.
module tb_serial_adder;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W)) bus ();
   serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: {carry,sum} is the plain sum; ovf is the signed result leaving the W-bit range.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int unsigned t;
      t = int'(a) + int'(b) + int'(c);
      return t[W:0];
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int sa;
      sa = int'($signed(a)) + int'($signed(b)) + int'(c);
      return (sa > 7) || (sa < -8);
   endfunction

   // Issue one operation from IDLE, scramble operands after acceptance, check result and timing.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
      logic [W:0]   exp;
      logic [W-1:0] prev_sum;
      int           lat;
      bit           stable;
      exp      = ref_sum(a, b, c);
      prev_sum = bus.sum;
      bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      chk({tag, " busy_after_accept"}, bus.busy, 1);
      lat = 0;
      stable = 1'b1;
      while (!bus.done && lat < 20) begin
         if (bus.sum !== prev_sum) stable = 1'b0;
         step();
         lat++;
      end
      chk({tag, " latency"}, lat, W);
      chk({tag, " sum_stable_while_running"}, stable, 1);
      chk({tag, " sum"}, bus.sum, exp[W-1:0]);
      chk({tag, " carry"}, bus.carry, exp[W]);
      chk({tag, " busy_in_done"}, bus.busy, 1);
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, " ovf"}, bus.ovf, ref_ovf(a, b, c));
`endif
      step();
      chk({tag, " done_one_cycle"}, bus.done, 0);
      chk({tag, " busy_cleared"}, bus.busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ha[0:35];
      logic [W-1:0] hb[0:35];
      logic         hc[0:35];
      logic [W:0]   e;
      logic [8:0]   idx;
      bit           no_done;

      tbl[0] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1};
      tbl[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
      tbl[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
      tbl[3] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
      tbl[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
      tbl[5] = '{4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0};
      tbl[6] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
      tbl[7] = '{4'h7, 4'h0, 1'b1, 4'h8, 1'b0, 1'b1};

      // Reset state
      rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("reset sum", bus.sum, 0);
      chk("reset carry", bus.carry, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("reset ovf", bus.ovf, 0);
`endif

      // Directed table: constants, checked through the same op sequence
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] a0, b0;
         logic         c0;
         a0 = tbl[i].a; b0 = tbl[i].b; c0 = tbl[i].cin;
         bus.a = a0; bus.b = b0; bus.cin = c0; bus.start = 1'b1;
         step();
         bus.start = 1'b0;
         for (int k = 0; k < W && !bus.done; k++) step();
         chk($sformatf("table%0d done", i), bus.done, 1);
         chk($sformatf("table%0d sum", i), bus.sum, tbl[i].sum);
         chk($sformatf("table%0d carry", i), bus.carry, tbl[i].carry);
`ifdef SERIAL_ADDER_OVF_EN
         chk($sformatf("table%0d ovf", i), bus.ovf, tbl[i].ovf);
`endif
         step();
      end

      // Reset during RUN aborts the operation
      run_op(4'hF, 4'hF, 1'b1, "pre_abort");
      bus.a = 4'h9; bus.b = 4'h6; bus.cin = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort sum", bus.sum, 0);
      chk("abort carry", bus.carry, 0);
      chk("abort busy", bus.busy, 0);
      chk("abort done", bus.done, 0);
      no_done = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
      end
      chk("abort no_done_after", no_done, 1);
      run_op(4'h2, 4'h2, 1'b0, "after_abort");

      // Random operations
      for (int i = 0; i < 60; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
      end

      // start held high, operands changing each cycle: acceptance every W+2 edges
      for (int k = 0; k < 36; k++) begin
         ha[k] = W'($urandom); hb[k] = W'($urandom); hc[k] = 1'($urandom);
         bus.a = ha[k]; bus.b = hb[k]; bus.cin = hc[k]; bus.start = 1'b1;
         step();
         chk($sformatf("held edge%0d done", k), bus.done, (k % 6 == 4) ? 1 : 0);
         chk($sformatf("held edge%0d busy", k), bus.busy, (k % 6 == 5) ? 0 : 1);
         if (k % 6 == 4) begin
            e = ref_sum(ha[k-4], hb[k-4], hc[k-4]);
            chk($sformatf("held edge%0d result", k), {bus.carry, bus.sum}, e);
         end
      end
      bus.start = 1'b0;

      // Exhaustive, back-to-back
      for (int i = 0; i < 512; i++) begin
         idx = 9'(i);
         run_op(idx[3:0], idx[7:4], idx[8], $sformatf("exh%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
